qspi_rx_aligner: RTL and testbench
==================================

Name: qspi_rx_aligner

Overview:
Read-data capture stage directly downstream of the QSPI data pins (data_in[3:0] behind the board/PMOD round-trip delay).
- Delays the controller's nibble-sample strobe by a programmable latency and captures qspi_data_in on the delayed strobe.
- Packs nibbles into bytes, high nibble first, and buffers them in a small FIFO for the instruction/data fetch logic.
- Decouples pad round-trip latency (0-5 clk) from the QSPI sequencer.

Parameters:
MAX_LATENCY, 5, largest supported strobe delay in clk cycles; latency_cfg values above this clamp to it
FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
latency_cfg  input  3  pad round-trip latency in clk cycles; captured on start
start  input  1  one-cycle pulse; begins a read of len_m1+1 bytes
len_m1  input  8  byte count minus one (0 = 1 byte, 255 = 256 bytes); captured on start
abort  input  1  one-cycle pulse; cancels the read and flushes the FIFO
sample_req  input  1  high in the cycle a nibble would be valid at the pins with zero latency
qspi_data_in  input  4  raw QSPI data nibble {io3,io2,io1,io0}
data_out  output  8  FIFO head byte
data_valid  output  1  FIFO non-empty
data_ready  input  1  consumer pop; a pop occurs when data_valid && data_ready
busy  output  1  read in progress
done  output  1  one-cycle pulse after the final byte of a read is pushed
overflow  output  1  sticky FIFO-overflow flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; strobe pipeline, nibble phase, byte counter and FIFO pointers cleared; lat_q = 0.
- On start: lat_q <= min(latency_cfg, MAX_LATENCY); remaining <= len_m1; nibble phase <= high; strobe pipeline cleared; FIFO flushed; busy <= 1 on the next cycle.
- A start while busy restarts the read: the in-flight read is discarded and no done pulse is issued for it.
- Strobe pipeline: shift register strb_sr[1..MAX_LATENCY], strb_sr[1] <= sample_req && busy.
  - Effective strobe: if lat_q = 0, sample_req && busy (same cycle); otherwise strb_sr[lat_q].
  - Total delay from sample_req to capture is exactly lat_q cycles.
- On an effective strobe:
  - High phase: hold qspi_data_in as the upper nibble; go to low phase.
  - Low phase: push {held, qspi_data_in} into the FIFO; go to high phase.
    - If remaining = 0: busy <= 0; done = 1 for the next cycle.
    - Otherwise remaining decrements.
- Strobes in flight after busy falls are discarded. strb_sr still drains but is gated by a per-read "armed" flag that clears when the last byte is pushed.
- abort: same cycle flush of strobe pipeline, nibble phase, counter and FIFO; busy <= 0; no done pulse. abort and start together: abort wins and start is ignored.
- FIFO: first-word fall-through; data_out is valid whenever data_valid = 1.
  - Push and pop in the same cycle are legal at any occupancy, including full, and neither is lost.
  - Push with FIFO full and no pop: the byte is dropped and the overflow condition is raised.
  - Pop when empty is ignored.
- Byte counter wraps never; reads of 256 bytes are supported via len_m1 = 255.
- latency_cfg changes while busy have no effect until the next start.

Optional Feature:
QSPI_RX_OVF_EN
- Defined: overflow is set on a dropped push. It clears only on start or reset; abort does not clear it.
- Not defined: overflow is tied to 0 and no overflow logic is built. Dropped bytes are still discarded silently.

Test Plan:
- Latency 0: start, len_m1=1, sample_req for 4 consecutive cycles with nibbles A,B,C,D. Expect bytes 0xAB, 0xCD; done one cycle after the 0xCD push; busy then 0.
- Latency sweep: for latency_cfg 1..5, drive nibbles with a matching delay line of latency_cfg cycles. Expect bytes identical to the latency-0 case. latency_cfg=7 behaves as 5.
- Backpressure: data_ready=0, FIFO_DEPTH=4, read of 5 bytes 0x10..0x14. Expect FIFO holds 0x10..0x13 and 0x14 is dropped; with QSPI_RX_OVF_EN, overflow=1; without it, overflow=0.
- Full push+pop: FIFO full, data_ready=1 in the same cycle a new byte arrives. Expect no drop, overflow stays 0, output order preserved.
- Abort mid-read: latency 3, abort after 3 nibbles. Expect FIFO empty, busy 0, no done pulse, and in-flight strobes ignored. A following start, len_m1=0, nibbles 5,E yields 0x5E.
- Reset mid-read: assert rst asynchronously between clock edges. Expect all outputs 0 immediately; the next read works normally.

Source files
------------

// File: rtl/qspi_rx_aligner.sv
// QSPI read-data aligner: delays the nibble-sample strobe by the pad round-trip latency,
// packs nibbles into bytes (high nibble first) and buffers them in a FWFT byte FIFO.
// Optional sticky overflow flag is built when QSPI_RX_OVF_EN is defined.
module qspi_rx_aligner #(
  parameter int MAX_LATENCY = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] latency_cfg,
  input  logic       start,
  input  logic [7:0] len_m1,
  input  logic       abort,
  input  logic       sample_req,
  input  logic [3:0] qspi_data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0] MAX_LAT = 3'(MAX_LATENCY);

  logic [2:0]           lat_q;
  logic [MAX_LATENCY:1] strb_sr;
  logic                 armed;
  logic                 phase_lo;
  logic [7:0]           remaining;
  logic [3:0]           nib_hi_p0;

  logic                 start_acc;
  logic                 strb_tap;
  logic                 strb_eff;
  logic                 push;
  logic                 push_ok;
  logic                 pop;
  logic [7:0]           push_byte;

  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 fifo_empty;
  logic                 fifo_full;

  assign start_acc = start && !abort;

  // Stage 0: strobe tap selection (latency 0 bypasses the shift register)
  always_comb begin
    strb_tap = sample_req && armed;
    for (int i = 1; i <= MAX_LATENCY; i++) begin
      if (lat_q == 3'(i)) strb_tap = strb_sr[i];
    end
  end

  // Strobes still draining after the read ends are masked by armed.
  assign strb_eff  = strb_tap && armed;
  assign push      = strb_eff && phase_lo;
  assign push_byte = {nib_hi_p0, qspi_data_in};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && data_ready;
  assign push_ok    = push && (!fifo_full || pop);

  assign data_valid = !fifo_empty;
  assign data_out   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];
  assign busy       = armed;

  function automatic logic [2:0] clamp_lat(input logic [2:0] cfg);
    return (cfg > MAX_LAT) ? MAX_LAT : cfg;
  endfunction

  // Stage 1: control state, strobe pipeline and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q     <= 3'd0;
      strb_sr   <= '0;
      armed     <= 1'b0;
      phase_lo  <= 1'b0;
      remaining <= 8'd0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        strb_sr   <= '0;
        armed     <= 1'b0;
        phase_lo  <= 1'b0;
        remaining <= 8'd0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else if (start) begin
        lat_q     <= clamp_lat(latency_cfg);
        remaining <= len_m1;
        phase_lo  <= 1'b0;
        strb_sr   <= '0;
        armed     <= 1'b1;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        strb_sr[1] <= sample_req && armed;
        for (int i = 2; i <= MAX_LATENCY; i++) begin
          strb_sr[i] <= strb_sr[i-1];
        end
        if (strb_eff) begin
          phase_lo <= !phase_lo;
          if (phase_lo) begin
            if (remaining == 8'd0) begin
              armed <= 1'b0;
              done  <= 1'b1;
            end else begin
              remaining <= remaining - 8'd1;
            end
          end
        end
        if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
        if (pop)     rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Stage 1: datapath storage (no reset on data)
  always_ff @(posedge clk) begin
    if (strb_eff && !phase_lo) nib_hi_p0 <= qspi_data_in;
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_byte;
  end

`ifdef QSPI_RX_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (start_acc) begin
      overflow <= 1'b0;
    end else if (!abort && push && !push_ok) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_rx_aligner.sv
// Directed bench for qspi_rx_aligner: byte scoreboard checked by a negedge monitor,
// plus control-flag assertions along a linear stimulus sequence.
module tb_qspi_rx_aligner;

  logic       clk;
  logic       rst;
  logic [2:0] latency_cfg;
  logic       start;
  logic [7:0] len_m1;
  logic       abort;
  logic       sample_req;
  logic [3:0] qspi_data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       done;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  qspi_rx_aligner #(.MAX_LATENCY(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .latency_cfg(latency_cfg), .start(start), .len_m1(len_m1),
    .abort(abort), .sample_req(sample_req), .qspi_data_in(qspi_data_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Byte scoreboard: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_byte: observed %h expected none", data_out);
        end
      end else begin
        chk8("byte", data_out, exp_q.pop_front());
      end
    end
  end

  // One read: nibbles presented at the pins lat cycles after their sample_req.
  task automatic run_read(input int lat_cfg, input logic [7:0] base, input logic [7:0] stp,
                          input int nbytes, input int keep, input int ready_from);
    int eff;
    int last;
    logic [3:0] nib[$];
    logic [7:0] b;
    eff = (lat_cfg > 5) ? 5 : lat_cfg;
    nib.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = base + 8'(i) * stp;
      nib.push_back(b[7:4]);
      nib.push_back(b[3:0]);
      if (i < keep) exp_q.push_back(b);
    end
    latency_cfg = 3'(lat_cfg);
    len_m1      = 8'(nbytes - 1);
    start       = 1'b1;
    step();
    start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
    last = 2 * nbytes - 1 + eff;
    for (int c = 0; c <= last; c++) begin
      sample_req   = (c < 2 * nbytes);
      qspi_data_in = (c >= eff && c - eff < 2 * nbytes) ? nib[c - eff] : 4'($urandom);
      if (c >= ready_from) data_ready = 1'b1;
      latency_cfg  = 3'($urandom);
      step();
      chk1("done", done, c == last);
      chk1("busy", busy, c < last);
    end
    sample_req = 1'b0;
    step();
    chk1("done_single_pulse", done, 1'b0);
  endtask

  initial begin
    rst = 1'b0; latency_cfg = 3'd0; start = 1'b0; len_m1 = 8'd0; abort = 1'b0;
    sample_req = 1'b0; qspi_data_in = 4'h0; data_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk1("rst_data_valid", data_valid, 1'b0);
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Latency 0 then sweep, including an out-of-range setting
    run_read(0, 8'hAB, 8'h22, 2, 2, 0);
    idle(3);
    for (int l = 1; l <= 7; l++) begin
      if (l != 6) begin
        run_read(l, 8'hAB, 8'h22, 2, 2, 0);
        idle(3);
      end
    end
    run_read(4, 8'h3C, 8'h45, 6, 6, 0);
    idle(3);

    // Backpressure: fifth byte dropped
    data_ready = 1'b0;
    run_read(0, 8'h10, 8'h01, 5, 4, 1000);
`ifdef QSPI_RX_OVF_EN
    chk1("ovf_after_drop", overflow, 1'b1);
`else
    chk1("ovf_after_drop", overflow, 1'b0);
`endif
    chk1("bp_valid", data_valid, 1'b1);
    chk8("bp_head", data_out, 8'h10);
    data_ready = 1'b1;
    idle(6);
    chk1("bp_drained", data_valid, 1'b0);
`ifdef QSPI_RX_OVF_EN
    chk1("ovf_sticky", overflow, 1'b1);
`endif

    // Full FIFO with simultaneous push and pop
    data_ready = 1'b0;
    run_read(0, 8'h20, 8'h01, 5, 5, 9);
    chk1("full_pushpop_ovf", overflow, 1'b0);
    idle(6);
    chk1("full_pushpop_drained", data_valid, 1'b0);

    // Abort mid-read at latency 3
    data_ready = 1'b0;
    latency_cfg = 3'd3; len_m1 = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample_req = 1'b1; qspi_data_in = 4'($urandom);
      step();
    end
    abort = 1'b1; sample_req = 1'b1;
    step();
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_valid", data_valid, 1'b0);
    for (int c = 0; c < 6; c++) begin
      sample_req = (c < 2); qspi_data_in = 4'($urandom);
      step();
      chk1("abort_no_done", done, 1'b0);
      chk1("abort_no_push", data_valid, 1'b0);
    end
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk1("abort_beats_start", busy, 1'b0);
    data_ready = 1'b1;
    idle(2);
    run_read(3, 8'h5E, 8'h00, 1, 1, 0);
    idle(3);

    // Asynchronous reset in the middle of a read
    data_ready = 1'b0;
    latency_cfg = 3'd2; len_m1 = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample_req = 1'b1; qspi_data_in = 4'($urandom);
      step();
    end
    chk1("pre_rst_valid", data_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("arst_valid", data_valid, 1'b0);
    chk8("arst_data_out", data_out, 8'h00);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk1("arst_overflow", overflow, 1'b0);
    sample_req = 1'b0;
    idle(2);
    rst = 1'b0;
    data_ready = 1'b1;
    idle(2);
    run_read(2, 8'h9C, 8'h11, 2, 2, 0);
    idle(3);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
